hex_text_ctrl: RTL and testbench
================================

# hex_text_ctrl

Hex-text overlay controller for the 5x7 font engine. Owns a 16x8 character-cell buffer (valid bit plus hex nibble per cell) and turns the font engine's cell coordinates and 16-way glyph bit vector into a single pixel. It also schedules the buffer between two write requesters and a bulk-clear sequencer, so that buffer updates happen only during blanking. Sits between the font engine and the video output mux.

## Interface
Parameters:
- COLS, 16: cell columns covered (char_x 0..COLS-1)
- ROWS, 8: cell rows covered (char_y 0..ROWS-1)

Ports:
- clk  in  1  pixel clock; one clock only
- reset  in  1  synchronous, active-high
- blank  in  1  video blanking, same timing as the font engine's input
- char_x  in  7  cell column from font engine
- char_y  in  7  cell row from font engine
- char_data  in  16  glyph bit per hex digit, one cycle behind char_x/char_y
- wr_req_a  in  1  requester A write request; hold until ack_a
- wr_addr_a  in  7  {row[2:0], col[3:0]}
- wr_data_a  in  5  {valid, nibble[3:0]}
- ack_a  out  1  one-cycle write-done pulse for requester A
- wr_req_b, wr_addr_b, wr_data_b, ack_b  same as A, for requester B
- clear_req  in  1  pulse; invalidates all cells
- clear_busy  out  1  high while a clear is pending or running
- pixel  out  1  overlay pixel

## Operation
Reset values:
- pixel=0, ack_a=0, ack_b=0
- clear_busy=1
- state=CLEAR, clear counter=0, round-robin pointer=A

Reset always starts a full clear. Buffer contents are don't-care until that clear completes.

States:
- IDLE:
  - If clear_req: go to CLEAR, counter=0.
  - Else if blank and any request: the arbiter picks a winner, the buffer write commits at this edge, and the FSM goes to GRANT_A or GRANT_B.
  - Requests with blank=0 wait.
- GRANT_A / GRANT_B:
  - The matching ack is high for exactly this one cycle.
  - The round-robin pointer moves to the other requester.
  - Next state is always IDLE, which gives at most one write per 2 cycles.
- CLEAR:
  - Each edge with blank=1 writes cell[counter]=0 and increments the counter.
  - The counter holds while blank=0.
  - The edge after the write of cell 127 goes to IDLE and drops clear_busy.
  - clear_req during CLEAR restarts the counter at 0.

Arbitration:
- Priority order: clear > write.
- Between A and B, round-robin: when both request, the one not granted last wins. A single requester wins unconditionally.
- A request arriving during CLEAR waits; it is never dropped.

Pixel path:
- Stage 1 registers cell = buffer[{char_y[2:0], char_x[3:0]}] and in_win = (char_x<COLS && char_y<ROWS && !blank).
- Stage 2: pixel <= in_win_d & cell.valid & char_data[cell.nibble].
- The display reads the buffer only when blank=0. Writes occur only when blank=1, so there is no read/write conflict and no tearing.

## Timing
- Pixel latency: 2 cycles from char_x/char_y; char_data is sampled 1 cycle after its coordinates.
- pixel is 0 on the 2 cycles following any blank=1 sample.
- Write latency: a request held with blank=1 in IDLE is acked on the next cycle. The written data is visible to a display read the cycle after the write edge.
- The requester drops wr_req the cycle after the ack. A request held through GRANT is re-arbitrated as a new write.
- Clear: exactly 128 blank=1 cycles after entry; clear_busy falls on the cycle state returns to IDLE.
- Reset mid-write or mid-clear: outputs return to reset values next edge and a new full clear begins. An in-flight ack is lost and the requester retries.

## Structure
- Package hex_text_pkg holds:
  - COLS/ROWS defaults
  - cell_t (packed: valid, nibble[3:0])
  - state enum (IDLE, GRANT_A, GRANT_B, CLEAR)
  - address field widths
- Sub-module hex_text_arb: 2-way round-robin arbiter with req[1:0], gate, grant[1:0] and a pointer register.
- The buffer is a register array inside hex_text_ctrl.

## Test plan
- Reset, then blank held high for 128 cycles: clear_busy stays 1 for 128 cycles, then 0. All pixels are 0 on the next frame.
- A writes addr 0x05 = {1,0xA} during blank: ack_a one cycle later. At char_x=5, char_y=0, pixel follows char_data[10] 2 cycles later.
- A and B request simultaneously with the pointer at A: A is acked first, B is acked 2 cycles after, and the pointer ends at A.
- Request held with blank=0 for 50 cycles: no ack. Blank rises, and ack follows 1 cycle later.
- clear_req with blank toggling 64 cycles high / 64 low / 64 high: clear_busy drops only after the 128th blank cycle. A pending B request is acked after the clear finishes.
- char_x=20 (outside COLS) with a valid cell aliasing: pixel stays 0. Reset asserted mid-GRANT_A: ack_a=0 next cycle and clear_busy=1.

Source files
------------

// File: rtl/hex_text_pkg.sv
// rtl/hex_text_pkg.sv - shared types and sizes for the hex-text overlay controller
package hex_text_pkg;

    localparam int COLS_DEF = 16;
    localparam int ROWS_DEF = 8;
    localparam int COL_W    = 4;
    localparam int ROW_W    = 3;
    localparam int ADDR_W   = COL_W + ROW_W;
    localparam int DEPTH    = 1 << ADDR_W;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } cell_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        CLEAR   = 2'd3
    } state_t;

endpackage

// File: rtl/hex_text_arb.sv
// rtl/hex_text_arb.sv - two-way round-robin arbiter for buffer write requesters
module hex_text_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       gate,
    output logic [1:0] grant
);

    // ptr_q names the requester that wins a tie: 0 = A, 1 = B
    logic ptr_q, ptr_d;

    always_comb begin
        grant = 2'b00;
        ptr_d = ptr_q;
        if (gate) begin
            if (req == 2'b11) begin
                grant = ptr_q ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
        end
        if (grant[0]) begin
            ptr_d = 1'b1;
        end else if (grant[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/hex_text_ctrl.sv
// rtl/hex_text_ctrl.sv - 16x8 hex character buffer, blank-time write scheduler and pixel path
module hex_text_ctrl
    import hex_text_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        blank,
    input  logic [6:0]  char_x,
    input  logic [6:0]  char_y,
    input  logic [15:0] char_data,
    input  logic        wr_req_a,
    input  logic [6:0]  wr_addr_a,
    input  logic [4:0]  wr_data_a,
    output logic        ack_a,
    input  logic        wr_req_b,
    input  logic [6:0]  wr_addr_b,
    input  logic [4:0]  wr_data_b,
    output logic        ack_b,
    input  logic        clear_req,
    output logic        clear_busy,
    output logic        pixel
);

    localparam logic [6:0] COLS_LIM = 7'(COLS);
    localparam logic [6:0] ROWS_LIM = 7'(ROWS);

    cell_t             buf_q [DEPTH];
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [1:0]        grant;
    logic              gate;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    cell_t             wr_cell;
    cell_t             cell_q;
    logic              in_win_q;
    logic              pixel_q;

    // Writes are only offered while idle in blanking with no clear outstanding
    assign gate = (state_q == IDLE) && blank && !clear_req && !pend_q;

    hex_text_arb u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({wr_req_b, wr_req_a}),
        .gate  (gate),
        .grant (grant)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        wr_en   = 1'b0;
        wr_addr = cnt_q;
        wr_cell = '0;
        case (state_q)
            IDLE: begin
                if (clear_req || pend_q) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else if (grant[0]) begin
                    wr_en   = 1'b1;
                    wr_addr = wr_addr_a;
                    wr_cell = cell_t'(wr_data_a);
                    state_d = GRANT_A;
                end else if (grant[1]) begin
                    wr_en   = 1'b1;
                    wr_addr = wr_addr_b;
                    wr_cell = cell_t'(wr_data_b);
                    state_d = GRANT_B;
                end
            end
            GRANT_A, GRANT_B: begin
                // A clear pulse landing in the ack cycle is held, not dropped
                state_d = IDLE;
                if (clear_req) begin
                    pend_d = 1'b1;
                end
            end
            CLEAR: begin
                if (clear_req) begin
                    cnt_d = '0;
                end else if (blank) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            in_win_q <= 1'b0;
            pixel_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            in_win_q <= (char_x < COLS_LIM) && (char_y < ROWS_LIM) && !blank;
            pixel_q  <= in_win_q & cell_q.valid & char_data[cell_q.nibble];
        end
    end

    // Buffer has no reset; its contents are rebuilt by the clear that reset starts
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            buf_q[wr_addr] <= wr_cell;
        end
        cell_q <= buf_q[{char_y[ROW_W-1:0], char_x[COL_W-1:0]}];
    end

    assign ack_a      = (state_q == GRANT_A);
    assign ack_b      = (state_q == GRANT_B);
    assign clear_busy = (state_q == CLEAR) || pend_q;
    assign pixel      = pixel_q;

endmodule

// File: tb/tb_hex_text_ctrl.sv
// tb/tb_hex_text_ctrl.sv - randomized scoreboard bench for hex_text_ctrl
module tb_hex_text_ctrl;

    logic        clk = 1'b0;
    logic        reset, blank;
    logic [6:0]  char_x, char_y;
    logic [15:0] char_data;
    logic        wr_req_a, wr_req_b;
    logic [6:0]  wr_addr_a, wr_addr_b;
    logic [4:0]  wr_data_a, wr_data_b;
    logic        ack_a, ack_b;
    logic        clear_req, clear_busy, pixel;

    always #5 clk = ~clk;

    hex_text_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .blank      (blank),
        .char_x     (char_x),
        .char_y     (char_y),
        .char_data  (char_data),
        .wr_req_a   (wr_req_a),
        .wr_addr_a  (wr_addr_a),
        .wr_data_a  (wr_data_a),
        .ack_a      (ack_a),
        .wr_req_b   (wr_req_b),
        .wr_addr_b  (wr_addr_b),
        .wr_data_b  (wr_data_b),
        .ack_b      (ack_b),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .pixel      (pixel)
    );

    typedef struct { int due; bit a; bit b; bit busy; } ctl_t;
    typedef struct { int due; bit chk; bit val; } pix_t;

    ctl_t ctl_q[$];
    pix_t pix_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: buffer image, clear progress, and requester bookkeeping
    bit [4:0]    mem [128];
    bit          known [128];
    bit          clearing, pend, cool, last_a;
    int          clear_left;
    int          ph [2];
    logic [6:0]  rq_addr [2];
    logic [4:0]  rq_data [2];
    logic [15:0] glyph_next;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    ctl_t mc;
    pix_t mp;
    always @(negedge clk) begin
        if (ctl_q.size() > 0 && ctl_q[0].due == cyc) begin
            mc = ctl_q.pop_front();
            chk("ack_a", int'(ack_a), int'(mc.a));
            chk("ack_b", int'(ack_b), int'(mc.b));
            chk("clear_busy", int'(clear_busy), int'(mc.busy));
        end
        if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
            mp = pix_q.pop_front();
            if (mp.chk) chk("pixel", int'(pixel), int'(mp.val));
        end
    end

    task automatic step(input bit rst, input bit blk, input bit clr);
        int   idx, w;
        bit   ga;
        pix_t p, pl;
        ctl_t c;
        @(posedge clk);
        #1;
        char_data = glyph_next;
        for (int r = 0; r < 2; r++) begin
            if (ph[r] == 0) begin
                if ($urandom_range(5) == 0) begin
                    ph[r]      = 1;
                    rq_addr[r] = 7'($urandom_range(127));
                    rq_data[r] = {($urandom_range(3) != 0), 4'($urandom_range(15))};
                end
            end else if (ph[r] == 2) begin
                ph[r] = 3;
            end else if (ph[r] == 3) begin
                ph[r] = 0;
            end
        end
        wr_req_a   = (ph[0] == 1 || ph[0] == 3);
        wr_req_b   = (ph[1] == 1 || ph[1] == 3);
        wr_addr_a  = rq_addr[0];
        wr_data_a  = rq_data[0];
        wr_addr_b  = rq_addr[1];
        wr_data_b  = rq_data[1];
        char_x     = 7'($urandom_range(19));
        char_y     = 7'($urandom_range(9));
        glyph_next = 16'($urandom);
        blank      = blk;
        reset      = rst;
        clear_req  = clr;

        // Pixel for these coordinates appears two edges later
        idx   = {char_y[2:0], char_x[3:0]};
        p.due = cyc + 2;
        if (rst || blk || char_x >= 16 || char_y >= 8) begin
            p.chk = 1;
            p.val = 0;
        end else begin
            p.chk = known[idx];
            p.val = mem[idx][4] && glyph_next[mem[idx][3:0]];
        end
        if (rst && pix_q.size() > 0) begin
            pl = pix_q.pop_back();
            pl.chk = 1;
            pl.val = 0;
            pix_q.push_back(pl);
        end
        pix_q.push_back(p);

        c.due = cyc + 1;
        c.a   = 0;
        c.b   = 0;
        if (rst) begin
            clearing   = 1;
            clear_left = 128;
            pend       = 0;
            cool       = 0;
            last_a     = 0;
            foreach (known[i]) known[i] = 0;
        end else if (clearing) begin
            if (clr) begin
                clear_left = 128;
            end else if (blk) begin
                mem[128 - clear_left]   = 0;
                known[128 - clear_left] = 1;
                clear_left--;
                if (clear_left == 0) clearing = 0;
            end
        end else if (cool) begin
            cool = 0;
            if (clr) pend = 1;
        end else if (clr || pend) begin
            clearing   = 1;
            clear_left = 128;
            pend       = 0;
        end else if (blk && (wr_req_a || wr_req_b)) begin
            ga = wr_req_a && !(wr_req_b && last_a);
            w  = ga ? 0 : 1;
            mem[rq_addr[w]]   = rq_data[w];
            known[rq_addr[w]] = 1;
            c.a    = ga;
            c.b    = !ga;
            last_a = ga;
            ph[w]  = 2;
            cool   = 1;
        end
        c.busy = clearing || pend;
        ctl_q.push_back(c);
    endtask

    initial begin
        bit blk_state;
        int seg_left;
        ph[0] = 0; ph[1] = 0;
        rq_addr[0] = '0; rq_addr[1] = '0;
        rq_data[0] = '0; rq_data[1] = '0;
        glyph_next = '0;
        clearing = 1; clear_left = 128; pend = 0; cool = 0; last_a = 0;
        foreach (known[i]) known[i] = 0;
        reset = 1; blank = 1; clear_req = 0;
        char_x = '0; char_y = '0; char_data = '0;
        wr_req_a = 0; wr_req_b = 0;
        wr_addr_a = '0; wr_addr_b = '0; wr_data_a = '0; wr_data_b = '0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 130; i++) step(1'b0, 1'b1, 1'b0);

        blk_state = 1'b1;
        seg_left  = 0;
        for (int i = 0; i < 5000; i++) begin
            if (seg_left == 0) begin
                blk_state = !blk_state;
                seg_left  = blk_state ? $urandom_range(40, 1) : $urandom_range(60, 1);
            end
            seg_left--;
            step(i == 2500, blk_state, $urandom_range(199) == 0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
